// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, LSU and memory-port signals shared through one arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_kill_i;
  logic              if_ack_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              lsu_req_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic              lsu_we_i;
  logic [DATA_W/8-1:0] lsu_sel_i;
  logic [DATA_W-1:0] lsu_wdata_i;
  logic              lsu_ack_o;
  logic [DATA_W-1:0] lsu_rdata_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_we_o;
  logic [DATA_W/8-1:0] mem_sel_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;
  modport slave (
    input  if_req_i, if_addr_i, if_kill_i, lsu_req_i, lsu_addr_i, lsu_we_i, lsu_sel_i, lsu_wdata_i,
           mem_ack_i, mem_rdata_i,
    output if_ack_o, if_rdata_o, lsu_ack_o, lsu_rdata_o,
           mem_req_o, mem_addr_o, mem_we_o, mem_sel_o, mem_wdata_o
  );
  modport master (
    output if_req_i, if_addr_i, if_kill_i, lsu_req_i, lsu_addr_i, lsu_we_i, lsu_sel_i, lsu_wdata_i,
           mem_ack_i, mem_rdata_i,
    input  if_ack_o, if_rdata_o, lsu_ack_o, lsu_rdata_o,
           mem_req_o, mem_addr_o, mem_we_o, mem_sel_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: LSU-priority arbiter for one memory port, with fetch starvation guard and fetch kill
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave b
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, LSU_BUSY} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t state, state_nx;
  logic [3:0] starve_cnt;
  logic kill_flag, if_cand, if_win, lsu_win;
  assign b.if_rdata_o  = b.mem_rdata_i;
  assign b.lsu_rdata_o = b.mem_rdata_i;
  always_comb begin
    if_cand     = b.if_req_i & ~b.if_kill_i;
    if_win      = if_cand & (~b.lsu_req_i | (starve_cnt >= LIMIT));
    lsu_win     = ~if_win & b.lsu_req_i;
    state_nx    = state == IDLE ? (if_win ? IF_BUSY : (lsu_win ? LSU_BUSY : IDLE))
                                : (b.mem_ack_i ? IDLE : state);
    b.lsu_ack_o = rst_n & (state == LSU_BUSY) & b.mem_ack_i;
    b.if_ack_o  = rst_n & (state == IF_BUSY) & b.mem_ack_i & ~kill_flag & ~b.if_kill_i;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt    <= '0;
      kill_flag     <= 1'b0;
      b.mem_req_o   <= 1'b0;
      b.mem_we_o    <= 1'b0;
      b.mem_addr_o  <= {ADDR_W{1'b0}};
      b.mem_sel_o   <= '0;
      b.mem_wdata_o <= {DATA_W{1'b0}};
    end else if (state == IDLE) begin
      if (if_win) begin
        b.mem_req_o   <= 1'b1;
        b.mem_addr_o  <= b.if_addr_i;
        b.mem_we_o    <= 1'b0;
        b.mem_sel_o   <= '1;
        b.mem_wdata_o <= {DATA_W{1'b0}};
      end else if (lsu_win) begin
        b.mem_req_o   <= 1'b1;
        b.mem_addr_o  <= b.lsu_addr_i;
        b.mem_we_o    <= b.lsu_we_i;
        b.mem_sel_o   <= b.lsu_sel_i;
        b.mem_wdata_o <= b.lsu_wdata_i;
      end
      starve_cnt <= (if_win || !b.if_req_i) ? 4'd0
                  : (lsu_win && if_cand && starve_cnt != 4'hF) ? starve_cnt + 4'd1 : starve_cnt;
    end else begin
      // a fetch killed mid-flight still completes on the bus, only its ack is withheld
      kill_flag <= (state == IF_BUSY) & ~b.mem_ack_i & (kill_flag | b.if_kill_i);
      if (b.mem_ack_i) b.mem_req_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with requester and memory-slave models
module tb_mem_port_arbiter;
  typedef struct {
    bit          lsu;
    bit          kill;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } txn_t;
  logic clk = 1'b0;
  logic rst_n;
  int errors = 0, checks = 0, cyc = 0, ws = 0, cnt = 0;
  bit stray = 0, kill_now = 0, prev_req = 0;
  logic [31:0] if_q[$];
  txn_t lsu_q[$], exp_q[$], pend[$];
  int grant_cyc[$], lsu_ack_cyc[$], raise_cyc[$];
  mem_port_arbiter_if mp();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (.clk(clk), .rst_n(rst_n), .b(mp));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_fn(logic [31:0] a);
    return a == 32'h80 ? 32'h13 : {a[15:0], ~a[15:0]};
  endfunction
  always @(posedge clk) begin
    #1;
    if (!mp.mem_req_o || mp.mem_ack_i) begin
      mp.mem_ack_i = 1'b0;
      cnt = 0;
    end else if (cnt == ws) begin
      mp.mem_ack_i   = 1'b1;
      mp.mem_rdata_i = mem_fn(mp.mem_addr_o);
    end else cnt++;
    if (stray) begin
      mp.mem_ack_i   = 1'b1;
      mp.mem_rdata_i = 32'hFFFF_FFFF;
    end
  end
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic txn_t fx(logic [31:0] a, bit k);
    txn_t t;
    t.lsu = 0; t.kill = k; t.addr = a; t.we = 0; t.sel = 4'hF; t.wdata = 0;
    return t;
  endfunction
  function automatic txn_t lx(logic [31:0] a, bit we, logic [3:0] sel, logic [31:0] wd);
    txn_t t;
    t.lsu = 1; t.kill = 0; t.addr = a; t.we = we; t.sel = sel; t.wdata = wd;
    return t;
  endfunction
  task automatic add_f(logic [31:0] a, bit k);
    if_q.push_back(a);
    exp_q.push_back(fx(a, k));
  endtask
  task automatic add_l(txn_t t);
    lsu_q.push_back(t);
    exp_q.push_back(t);
  endtask
  task automatic tick();
    txn_t e, t;
    logic ia, la;
    @(negedge clk);
    cyc++;
    ia = mp.if_ack_o;
    la = mp.lsu_ack_o;
    if (mp.mem_req_o && !prev_req) begin
      grant_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("grant_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("grant_addr", mp.mem_addr_o, e.addr);
        check("grant_we", mp.mem_we_o, e.we);
        check("grant_sel", mp.mem_sel_o, e.sel);
        if (e.we) check("grant_wdata", mp.mem_wdata_o, e.wdata);
        pend.push_back(e);
      end
    end
    prev_req = mp.mem_req_o;
    if (mp.mem_ack_i && mp.mem_req_o && pend.size() > 0) begin
      e = pend.pop_front();
      check("lsu_ack", la, e.lsu);
      check("if_ack", ia, !e.lsu && !e.kill);
      if (e.lsu && !e.we) check("lsu_rdata", mp.lsu_rdata_o, mem_fn(e.addr));
      if (!e.lsu && !e.kill) check("if_rdata", mp.if_rdata_o, mem_fn(e.addr));
      if (la) lsu_ack_cyc.push_back(cyc);
    end else check("spurious_ack", {ia, la}, 2'b00);
    mp.if_kill_i = 1'b0;
    if (mp.if_req_i && (ia || kill_now)) begin
      mp.if_kill_i = kill_now;
      kill_now = 0;
      mp.if_req_i = 1'b0;
      void'(if_q.pop_front());
    end
    if (!mp.if_req_i && if_q.size() > 0) begin
      mp.if_req_i  = 1'b1;
      mp.if_addr_i = if_q[0];
      raise_cyc.push_back(cyc);
    end
    if (mp.lsu_req_i && la) begin
      mp.lsu_req_i = 1'b0;
      void'(lsu_q.pop_front());
    end
    if (!mp.lsu_req_i && lsu_q.size() > 0) begin
      t = lsu_q[0];
      mp.lsu_req_i   = 1'b1;
      mp.lsu_addr_i  = t.addr;
      mp.lsu_we_i    = t.we;
      mp.lsu_sel_i   = t.sel;
      mp.lsu_wdata_i = t.wdata;
      raise_cyc.push_back(cyc);
    end
  endtask
  function automatic bit idle();
    return exp_q.size() == 0 && pend.size() == 0 && if_q.size() == 0 && lsu_q.size() == 0
        && !mp.mem_req_o && !mp.if_req_i && !mp.lsu_req_i;
  endfunction
  task automatic run(int max);
    int i = 0;
    while (!idle() && i < max) begin
      tick();
      i++;
    end
    check("drain", idle(), 1);
  endtask
  task automatic clear_logs();
    grant_cyc.delete();
    lsu_ack_cyc.delete();
    raise_cyc.delete();
  endtask
  initial begin
    rst_n = 1'b0;
    {mp.if_req_i, mp.if_kill_i, mp.lsu_req_i, mp.lsu_we_i} = '0;
    mp.if_addr_i = '0; mp.lsu_addr_i = '0; mp.lsu_sel_i = '0; mp.lsu_wdata_i = '0;
    repeat (2) tick();
    check("rst_req", mp.mem_req_o, 0);
    check("rst_we", mp.mem_we_o, 0);
    check("rst_addr", mp.mem_addr_o, 0);
    check("rst_sel", mp.mem_sel_o, 0);
    check("rst_wdata", mp.mem_wdata_o, 0);
    rst_n = 1'b1;
    tick();
    ws = 2;
    clear_logs();
    add_f(32'h80, 0);
    run(40);
    check("fetch_latency", grant_cyc[0] - raise_cyc[0], 1);
    ws = 0;
    clear_logs();
    add_l(lx(32'h1000, 1, 4'h3, 32'hDEAD_BEEF));
    add_f(32'h84, 0);
    run(40);
    check("bubble_gap", grant_cyc[1] - grant_cyc[0], 2);
    for (int i = 0; i < 10; i++) lsu_q.push_back(lx(32'h4000 + 32'(i * 4), 0, 4'hF, 0));
    if_q.push_back(32'h100);
    if_q.push_back(32'h104);
    for (int i = 0; i < 12; i++)
      exp_q.push_back(i == 4 ? fx(32'h100, 0) : i == 9 ? fx(32'h104, 0)
                     : lx(32'h4000 + 32'((i - (i > 9 ? 2 : i > 4 ? 1 : 0)) * 4), 0, 4'hF, 0));
    run(200);
    ws = 3;
    add_f(32'h200, 1);
    for (int i = 0; i < 10 && !mp.mem_req_o; i++) tick();
    check("kill_grant", mp.mem_req_o, 1);
    kill_now = 1;
    tick();
    check("kill_hold", mp.mem_req_o, 1);
    add_f(32'h204, 0);
    run(60);
    ws = 5;
    add_l(lx(32'h3000, 0, 4'hF, 0));
    for (int i = 0; i < 10 && !mp.mem_req_o; i++) tick();
    check("rst_busy_grant", mp.mem_req_o, 1);
    rst_n = 1'b0;
    lsu_q.delete();
    pend.delete();
    mp.lsu_req_i = 1'b0;
    tick();
    check("rst_mid_req", mp.mem_req_o, 0);
    check("rst_mid_addr", mp.mem_addr_o, 0);
    tick();
    rst_n = 1'b1;
    ws = 1;
    add_l(lx(32'h3004, 0, 4'hF, 0));
    run(40);
    stray = 1;
    tick();
    stray = 0;
    repeat (2) tick();
    ws = 0;
    clear_logs();
    add_l(lx(32'h5000, 0, 4'hF, 0));
    add_l(lx(32'h5004, 0, 4'hF, 0));
    run(40);
    check("b2b_first", lsu_ack_cyc[0] - raise_cyc[0], 1);
    check("b2b_second", lsu_ack_cyc[1] - lsu_ack_cyc[0], 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory/bus slave between the instruction-fetch requester and the load-store requester.
- Sits between the fetch/LSU request ports and the core-external memory port.
- Fixed priority to LSU, with a starvation guard that forces a fetch grant after a bounded number of consecutive LSU wins.
- Registers the winning request and holds it until the slave acks.
- Supports fetch kill (flush) without aborting an in-flight memory access.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive LSU grants while fetch is waiting before fetch is forced; range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_req_i  in  1  fetch request; held until if_ack_o or if_kill_i
- if_addr_i  in  ADDR_W  fetch address
- if_kill_i  in  1  fetch flush; drops the pending or in-flight fetch
- if_ack_o  out  1  fetch response valid (1 cycle)
- if_rdata_o  out  DATA_W  fetch read data
- lsu_req_i  in  1  LSU request; held stable until lsu_ack_o
- lsu_addr_i  in  ADDR_W  LSU address
- lsu_we_i  in  1  1 = write
- lsu_sel_i  in  DATA_W/8  byte enables
- lsu_wdata_i  in  DATA_W  write data
- lsu_ack_o  out  1  LSU response valid (1 cycle)
- lsu_rdata_o  out  DATA_W  LSU read data
- mem_req_o  out  1  memory request; held until mem_ack_i
- mem_addr_o  out  ADDR_W  registered address
- mem_we_o  out  1  registered write enable; 0 for fetch
- mem_sel_o  out  DATA_W/8  registered byte enables; all-ones for fetch
- mem_wdata_o  out  DATA_W  registered write data
- mem_ack_i  in  1  memory response valid
- mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Reset
  - State IDLE; starve_cnt = 0; kill_flag = 0.
  - mem_req_o, mem_we_o, if_ack_o, lsu_ack_o = 0; mem_addr_o, mem_sel_o, mem_wdata_o = 0.
  - Reset asserted mid-transaction drops it immediately: no ack to either requester, mem_req_o low next cycle.
- FSM states: IDLE, IF_BUSY, LSU_BUSY.
- IDLE arbitration, evaluated every cycle:
  - Fetch candidate = if_req_i & ~if_kill_i.
  - Fetch wins if it is a candidate and (~lsu_req_i or starve_cnt >= STARVE_LIMIT).
  - Otherwise LSU wins if lsu_req_i. Otherwise stay IDLE.
- Grant
  - Registers the winner's fields into the mem_* outputs and sets mem_req_o = 1 at the next clock edge.
  - Latency: request sampled in cycle N → mem_req_o high in cycle N+1.
- Busy states
  - mem_req_o and all mem_* outputs are held stable until mem_ack_i.
  - On mem_ack_i, the owner's ack is driven combinationally in the same cycle: lsu_ack_o = mem_ack_i in LSU_BUSY; if_ack_o = mem_ack_i & ~kill_flag & ~if_kill_i in IF_BUSY.
  - rdata outputs pass mem_rdata_i straight through; their value is don't-care while the ack is low.
  - The next edge clears mem_req_o and returns to IDLE, so there is a minimum of one idle cycle between transactions.
  - Fastest round trip: request at N, ack at N+1, next grant sampled at N+2.
- Starvation counter
  - On each LSU grant while if_req_i & ~if_kill_i: starve_cnt increments, saturating at 15.
  - On each fetch grant, or on a cycle with no fetch request in IDLE: starve_cnt clears to 0.
- Fetch kill
  - In IDLE: suppresses the fetch candidate that cycle.
  - In IF_BUSY: sets kill_flag. The memory transaction still completes, but if_ack_o stays 0 for it. kill_flag clears on leaving IF_BUSY.
- Simultaneous events
  - mem_ack_i and if_kill_i in the same cycle: ack suppressed.
  - New requests arriving while busy wait for IDLE; they are never dropped.
- mem_ack_i in IDLE is ignored; no requester ack is generated.
- Acks are only driven in their owning busy state, so no requester ever sees more than one ack per grant.

Test Plan:
- Single fetch, if_addr_i = 0x80: mem_req_o rises 1 cycle later with mem_addr_o = 0x80, mem_we_o = 0, mem_sel_o = 0xF. Slave acks after 2 cycles with 0x00000013 → if_ack_o pulses once with if_rdata_o = 0x00000013; lsu_ack_o stays 0.
- Simultaneous if_req_i and LSU write (addr 0x1000, wdata 0xDEADBEEF, sel 0x3): LSU granted first with mem_we_o = 1, mem_sel_o = 0x3. Fetch is granted on the next IDLE cycle, 1 bubble later.
- LSU requests continuously, fetch requests continuously, STARVE_LIMIT = 4: grant order is L, L, L, L, F, then L, L, L, L, F repeating.
- Fetch in IF_BUSY, if_kill_i pulsed before mem_ack_i: mem_req_o stays high until ack, if_ack_o = 0, and the next arbitration proceeds normally.
- rst_n driven low during LSU_BUSY with the ack pending: next cycle mem_req_o = 0, state IDLE, no lsu_ack_o; a request after reset is granted normally.
- Slave with zero wait states, LSU back-to-back reads: lsu_ack_o at cycles N+1 and N+3, addresses match the requests in order.
